// File: rtl/alu_control_lm_19101664_pkg.sv
// -----------------------------------------------------------------------------
// alu_control_lm_19101664_pkg
// Shared definitions for the ALU control block:
//   - ALUop class encodings coming from the main control unit
//   - R-type funct[3:0] constants that the decoder recognises
//   - 4-bit ALU control codes driven to the datapath ALU
//   - a packed struct carrying one decode result (code + illegal flag)
// -----------------------------------------------------------------------------
package alu_control_lm_19101664_pkg;

   // ALU class selected by the main control unit. 2'b11 is not named:
   // it behaves exactly like RTYPE because only bit 1 selects R-type decode.
   typedef enum logic [1:0] {
      ALUOP_LW_SW = 2'b00,
      ALUOP_BEQ   = 2'b01,
      ALUOP_RTYPE = 2'b10
   } aluop_e;

   // Recognised R-type funct[3:0] patterns (funct[5:4] is never examined).
   localparam logic [3:0] FUNCT_ADD = 4'b0000;
   localparam logic [3:0] FUNCT_SUB = 4'b0010;
   localparam logic [3:0] FUNCT_AND = 4'b0100;
   localparam logic [3:0] FUNCT_OR  = 4'b0101;
   localparam logic [3:0] FUNCT_NOR = 4'b0111;
   localparam logic [3:0] FUNCT_SLT = 4'b1010;

   // ALU control codes.
   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_NOR = 4'b1100;

   // One decode result.
   typedef struct packed {
      logic [3:0] code;
      logic       illegal;
   } decode_t;

   // Both 2'b10 and 2'b11 request funct decode; bit 1 alone decides it.
   function automatic logic is_rtype(input logic [1:0] aluop);
      return aluop[1];
   endfunction

endpackage : alu_control_lm_19101664_pkg

// File: rtl/alu_control_lm_19101664_alu_ctrl_decode.sv
// -----------------------------------------------------------------------------
// alu_ctrl_decode
// Purely combinational ALU control decode.
// Ports:
//   funcfield [5:0] in  : R-type funct field (instr[5:0])
//   ALUop     [1:0] in  : main-control ALU class
//   code      [3:0] out : ALU control code
//   illegal         out : high when an R-type funct[3:0] is not supported
// Every input combination yields a defined code; unsupported R-type functs
// fall back to ADD so the datapath never sees an undefined operation.
// -----------------------------------------------------------------------------
module alu_ctrl_decode
   import alu_control_lm_19101664_pkg::*;
(
   input  logic [5:0] funcfield,
   input  logic [1:0] ALUop,
   output logic [3:0] code,
   output logic       illegal
);

   decode_t    dec_s;
   logic [3:0] funct_lo_s;
   logic       unused_funct_hi_s;

   assign funct_lo_s = funcfield[3:0];

   // Upper funct bits are deliberately ignored by the decode.
   assign unused_funct_hi_s = ^funcfield[5:4];

   // Decode ALU class first, then the R-type funct when requested.
   always_comb begin
      dec_s.code    = ALU_ADD;
      dec_s.illegal = 1'b0;
      if (is_rtype(ALUop)) begin
         case (funct_lo_s)
            FUNCT_ADD: dec_s.code = ALU_ADD;
            FUNCT_SUB: dec_s.code = ALU_SUB;
            FUNCT_AND: dec_s.code = ALU_AND;
            FUNCT_OR:  dec_s.code = ALU_OR;
            FUNCT_NOR: dec_s.code = ALU_NOR;
            FUNCT_SLT: dec_s.code = ALU_SLT;
            default: begin
               dec_s.code    = ALU_ADD;
               dec_s.illegal = 1'b1;
            end
         endcase
      end else begin
         case (ALUop)
            ALUOP_LW_SW: dec_s.code = ALU_ADD;
            ALUOP_BEQ:   dec_s.code = ALU_SUB;
            default:     dec_s.code = ALU_ADD;
         endcase
      end
   end

   assign code    = dec_s.code;
   assign illegal = dec_s.illegal;

endmodule : alu_ctrl_decode

// File: rtl/alu_control_lm_19101664.sv
// -----------------------------------------------------------------------------
// alu_control_lm_19101664
// Registered ALU control unit: one-cycle latency from a valid input to the
// ALU control code.
// Ports:
//   clk                in  : rising-edge clock
//   rst_n              in  : asynchronous active-low reset
//   funcfield    [5:0] in  : R-type funct field
//   ALUop        [1:0] in  : main-control ALU class
//   in_valid           in  : qualifies funcfield/ALUop this cycle
//   ALUoperation [3:0] out : registered ALU control code
//   out_valid          out : registered; result captured on the last edge
//   illegal            out : registered; captured R-type funct unsupported
// When in_valid is low the code and illegal flag hold, only out_valid drops.
// -----------------------------------------------------------------------------
module alu_control_lm_19101664
   import alu_control_lm_19101664_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] funcfield,
   input  logic [1:0] ALUop,
   input  logic       in_valid,
   output logic [3:0] ALUoperation,
   output logic       out_valid,
   output logic       illegal
);

   logic [3:0] dec_code_s;
   logic       dec_illegal_s;

   alu_ctrl_decode u_decode (
      .funcfield (funcfield),
      .ALUop     (ALUop),
      .code      (dec_code_s),
      .illegal   (dec_illegal_s)
   );

   // Output registers: capture decode on a valid edge, otherwise hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ALUoperation <= 4'b0000;
         illegal      <= 1'b0;
         out_valid    <= 1'b0;
      end else if (in_valid) begin
         ALUoperation <= dec_code_s;
         illegal      <= dec_illegal_s;
         out_valid    <= 1'b1;
      end else begin
         ALUoperation <= ALUoperation;
         illegal      <= illegal;
         out_valid    <= 1'b0;
      end
   end

endmodule : alu_control_lm_19101664

// File: tb/tb_alu_control_lm_19101664.sv
module tb_alu_control_lm_19101664;

   logic       clk;
   logic       rst_n;
   logic [5:0] funcfield;
   logic [1:0] ALUop;
   logic       in_valid;
   logic [3:0] ALUoperation;
   logic       out_valid;
   logic       illegal;

   int checks = 0;
   int errors = 0;

   // reference model state (what the outputs should be now)
   logic [3:0] m_op;
   logic       m_ill;
   logic       m_vld;

   typedef struct {
      logic       v;
      logic [1:0] a;
      logic [5:0] f;
      logic [3:0] op;
      logic       ill;
      logic       vld;
   } vec_t;

   vec_t vecs[$];

   alu_control_lm_19101664 dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .funcfield    (funcfield),
      .ALUop        (ALUop),
      .in_valid     (in_valid),
      .ALUoperation (ALUoperation),
      .out_valid    (out_valid),
      .illegal      (illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: table lookup of the supported R-type functs.
   function automatic logic [4:0] ref_decode(input logic [1:0] a, input logic [5:0] f);
      int keys  [6] = '{0, 2, 4, 5, 10, 7};
      int codes [6] = '{2, 6, 0, 1, 7, 12};
      int lo;
      if (a == 2'd0) return {4'd2, 1'b0};
      if (a == 2'd1) return {4'd6, 1'b0};
      lo = int'(f) % 16;
      for (int k = 0; k < 6; k++)
         if (keys[k] == lo) return {codes[k][3:0], 1'b0};
      return {4'd2, 1'b1};
   endfunction

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%b required=%b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_all(input string name, input logic [3:0] op,
                            input logic ill, input logic vld);
      check({name, ".op"},  ALUoperation, op);
      check({name, ".ill"}, {3'b000, illegal}, {3'b000, ill});
      check({name, ".vld"}, {3'b000, out_valid}, {3'b000, vld});
   endtask

   // drive inputs (away from the edge), clock once, sample 1 after the edge
   task automatic apply(input logic v, input logic [1:0] a, input logic [5:0] f);
      logic [4:0] r;
      in_valid  = v;
      ALUop     = a;
      funcfield = f;
      @(posedge clk);
      #1;
      if (v) begin
         r     = ref_decode(a, f);
         m_op  = r[4:1];
         m_ill = r[0];
         m_vld = 1'b1;
      end else begin
         m_vld = 1'b0;
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b1;
      ALUop     = 2'b01;
      funcfield = 6'd0;
      m_op = 4'd0; m_ill = 1'b0; m_vld = 1'b0;

      // reset state while inputs are valid
      #2;
      check_all("reset_init", 4'b0000, 1'b0, 1'b0);
      @(posedge clk); #1;
      check_all("reset_held", 4'b0000, 1'b0, 1'b0);
      rst_n = 1'b1;

      // asynchronous reset with no clock edge in between
      apply(1'b1, 2'b01, 6'd0);
      check_all("pre_async", 4'b0110, 1'b0, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check_all("async_reset", 4'b0000, 1'b0, 1'b0);
      #2 rst_n = 1'b1;
      m_op = 4'd0; m_ill = 1'b0; m_vld = 1'b0;

      // directed table
      vecs.push_back('{1'b1, 2'b00, 6'd0,       4'b0010, 1'b0, 1'b1});
      vecs.push_back('{1'b1, 2'b01, 6'd0,       4'b0110, 1'b0, 1'b1});
      vecs.push_back('{1'b1, 2'b10, 6'd0,       4'b0010, 1'b0, 1'b1});
      vecs.push_back('{1'b1, 2'b10, 6'd2,       4'b0110, 1'b0, 1'b1});
      vecs.push_back('{1'b1, 2'b10, 6'd4,       4'b0000, 1'b0, 1'b1});
      vecs.push_back('{1'b1, 2'b10, 6'd5,       4'b0001, 1'b0, 1'b1});
      vecs.push_back('{1'b1, 2'b10, 6'd10,      4'b0111, 1'b0, 1'b1});
      vecs.push_back('{1'b1, 2'b11, 6'd10,      4'b0111, 1'b0, 1'b1});
      vecs.push_back('{1'b1, 2'b11, 6'd2,       4'b0110, 1'b0, 1'b1});
      vecs.push_back('{1'b1, 2'b10, 6'b100111,  4'b1100, 1'b0, 1'b1});
      vecs.push_back('{1'b1, 2'b10, 6'b100011,  4'b0010, 1'b1, 1'b1});
      vecs.push_back('{1'b1, 2'b00, 6'b100011,  4'b0010, 1'b0, 1'b1});
      vecs.push_back('{1'b1, 2'b10, 6'd4,       4'b0000, 1'b0, 1'b1});
      vecs.push_back('{1'b0, 2'b10, 6'd5,       4'b0000, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 2'b10, 6'd5,       4'b0000, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 2'b10, 6'd5,       4'b0000, 1'b0, 1'b0});
      vecs.push_back('{1'b1, 2'b11, 6'b110011,  4'b0010, 1'b1, 1'b1});
      vecs.push_back('{1'b0, 2'b01, 6'd0,       4'b0010, 1'b1, 1'b0});
      vecs.push_back('{1'b1, 2'b10, 6'b010111,  4'b1100, 1'b0, 1'b1});
      foreach (vecs[i]) begin
         apply(vecs[i].v, vecs[i].a, vecs[i].f);
         check_all($sformatf("vec%0d", i), vecs[i].op, vecs[i].ill, vecs[i].vld);
      end

      // mid-stream reset discards in-flight result
      apply(1'b1, 2'b10, 6'd7);
      in_valid = 1'b1; ALUop = 2'b01; funcfield = 6'd0;
      #1 rst_n = 1'b0;
      m_op = 4'd0; m_ill = 1'b0; m_vld = 1'b0;
      @(posedge clk); #1;
      check_all("mid_reset", 4'b0000, 1'b0, 1'b0);
      rst_n = 1'b1;
      apply(1'b0, 2'b01, 6'd0);
      check_all("post_rel_idle", 4'b0000, 1'b0, 1'b0);
      apply(1'b1, 2'b10, 6'd5);
      check_all("post_rel_first", 4'b0001, 1'b0, 1'b1);

      // exhaustive sweep, back to back
      for (int n = 0; n < 256; n++) begin
         apply(1'b1, n[7:6], n[5:0]);
         check_all($sformatf("sweep%0d", n), m_op, m_ill, m_vld);
      end

      // randomized, mixed valid/idle
      for (int n = 0; n < 400; n++) begin
         apply(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
               2'($urandom_range(0, 3)), 6'($urandom_range(0, 63)));
         check_all($sformatf("rand%0d", n), m_op, m_ill, m_vld);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_alu_control_lm_19101664
